// File: rtl/quickq_pkg.sv
// Shared definitions for the QuickQ min-heap priority queue control path:
// state encoding, datapath mode codes, comparator operand selects, root index.
package quickq_pkg;

    // FSM states; four bits because there are nine states.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ENQ_WR    = 4'd1,
        ST_ENQ_CMP   = 4'd2,
        ST_ENQ_SWAP  = 4'd3,
        ST_DEQ_RD    = 4'd4,
        ST_DEQ_MOVE  = 4'd5,
        ST_DEQ_CHILD = 4'd6,
        ST_DEQ_CMP   = 4'd7,
        ST_DEQ_SWAP  = 4'd8
    } state_t;

    // Operation class reported to the datapath (code 7 is unused).
    localparam logic [2:0] MODE_IDLE     = 3'd0;
    localparam logic [2:0] MODE_ENQ_WR   = 3'd1;
    localparam logic [2:0] MODE_ENQ_CMP  = 3'd2;
    localparam logic [2:0] MODE_ENQ_SWAP = 3'd3;
    localparam logic [2:0] MODE_DEQ_MOVE = 3'd4;
    localparam logic [2:0] MODE_DEQ_CMP  = 3'd5;
    localparam logic [2:0] MODE_DEQ_SWAP = 3'd6;

    // Comparator operand selects.
    localparam logic [1:0] SEL_NONE     = 2'd0;
    localparam logic [1:0] SEL_PARENT   = 2'd1;
    localparam logic [1:0] SEL_CHILDREN = 2'd2;
    localparam logic [1:0] SEL_SWAP     = 2'd3;

    // Heap nodes are 1-based; the root lives at index 1.
    localparam int unsigned ROOT_ADDR = 32'd1;

    // Mode code presented while the FSM sits in a given state.
    function automatic logic [2:0] mode_of(input state_t st);
        logic [2:0] m;
        case (st)
            ST_ENQ_WR:    m = MODE_ENQ_WR;
            ST_ENQ_CMP:   m = MODE_ENQ_CMP;
            ST_ENQ_SWAP:  m = MODE_ENQ_SWAP;
            ST_DEQ_RD:    m = MODE_DEQ_MOVE;
            ST_DEQ_MOVE:  m = MODE_DEQ_MOVE;
            ST_DEQ_CHILD: m = MODE_DEQ_CMP;
            ST_DEQ_CMP:   m = MODE_DEQ_CMP;
            ST_DEQ_SWAP:  m = MODE_DEQ_SWAP;
            default:      m = MODE_IDLE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/control_fsm.sv
// QuickQ control FSM: sequences heap enqueue (append + sift up) and dequeue
// (tail to root + sift down). Outputs are registered alongside the state by
// decoding the next state and next index registers, so each output reflects
// exactly the state the FSM is in during that cycle.
module control_fsm
    import quickq_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enq,
    input  logic              deq,
    input  logic              done,
    input  logic              result,
    input  logic              full,
    input  logic              swap_done,
    input  logic              empty,
    output logic              we,
    output logic              regenb,
    output logic              regsel,
    output logic              countenb,
    output logic              re,
    output logic              next_node,
    output logic              bram_sel,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        mode,
    output logic [1:0]        mux1_sel
);

    localparam logic [ADDR_W-1:0] ROOT = ADDR_W'(ROOT_ADDR);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W-1:0] r_child;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_count_nxt;
    logic [ADDR_W-1:0] w_cur_nxt;
    logic [ADDR_W-1:0] w_child_nxt;

    logic [ADDR_W-1:0] w_count_inc;
    logic [ADDR_W-1:0] w_cur_parent;
    logic [ADDR_W-1:0] w_cur_left;
    logic [ADDR_W-1:0] w_child_left;
    logic              w_pick_right;

    logic              w_we;
    logic              w_regenb;
    logic              w_regsel;
    logic              w_countenb;
    logic              w_re;
    logic              w_next_node;
    logic              w_bram_sel;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [1:0]        w_mux1_sel;

    assign w_count_inc  = r_count + ONE;
    assign w_cur_parent = r_cur >> 1;
    assign w_cur_left   = r_cur << 1;
    assign w_child_left = r_child << 1;
    // Right child only wins if it actually exists in the heap.
    assign w_pick_right = result && ((w_cur_left + ONE) <= r_count);

    // Next-state and index-register update logic.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_cur_nxt   = r_cur;
        w_child_nxt = r_child;
        case (r_state)
            ST_IDLE: begin
                if (enq && !full) begin
                    w_state_nxt = ST_ENQ_WR;
                end else if (deq && !empty) begin
                    w_state_nxt = ST_DEQ_RD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ENQ_WR: begin
                w_count_nxt = w_count_inc;
                w_cur_nxt   = w_count_inc;
                if (w_count_inc == ROOT) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ENQ_CMP;
                end
            end
            ST_ENQ_CMP: begin
                if (done) begin
                    w_state_nxt = ST_IDLE;
                end else if (result) begin
                    w_state_nxt = ST_ENQ_SWAP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ENQ_SWAP: begin
                if (swap_done) begin
                    w_cur_nxt = w_cur_parent;
                    if (w_cur_parent == ROOT) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_ENQ_CMP;
                    end
                end else begin
                    w_state_nxt = ST_ENQ_SWAP;
                end
            end
            ST_DEQ_RD: begin
                w_count_nxt = r_count - ONE;
                w_state_nxt = ST_DEQ_MOVE;
            end
            ST_DEQ_MOVE: begin
                w_cur_nxt = ROOT;
                if (r_count <= ONE) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DEQ_CHILD;
                end
            end
            ST_DEQ_CHILD: begin
                w_child_nxt = w_cur_left + {{(ADDR_W-1){1'b0}}, w_pick_right};
                if (done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DEQ_CMP;
                end
            end
            ST_DEQ_CMP: begin
                if (done || !result) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DEQ_SWAP;
                end
            end
            ST_DEQ_SWAP: begin
                if (swap_done) begin
                    w_cur_nxt = r_child;
                    if (w_child_left > r_count) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DEQ_CHILD;
                    end
                end else begin
                    w_state_nxt = ST_DEQ_SWAP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Moore output decode for the upcoming state, using its index registers.
    always_comb begin
        w_we        = 1'b0;
        w_regenb    = 1'b0;
        w_regsel    = 1'b0;
        w_countenb  = 1'b0;
        w_re        = 1'b0;
        w_next_node = 1'b0;
        w_bram_sel  = 1'b0;
        w_rd_addr   = '0;
        w_wr_addr   = '0;
        w_mux1_sel  = SEL_NONE;
        case (w_state_nxt)
            ST_ENQ_WR: begin
                w_we       = 1'b1;
                w_wr_addr  = w_count_nxt + ONE;
                w_regenb   = 1'b1;
                w_regsel   = 1'b0;
                w_countenb = 1'b1;
            end
            ST_ENQ_CMP: begin
                w_re       = 1'b1;
                w_rd_addr  = w_cur_nxt >> 1;
                w_mux1_sel = SEL_PARENT;
            end
            ST_ENQ_SWAP: begin
                w_rd_addr  = w_cur_nxt;
                w_wr_addr  = w_cur_nxt >> 1;
                w_bram_sel = 1'b1;
                w_mux1_sel = SEL_SWAP;
            end
            ST_DEQ_RD: begin
                w_re       = 1'b1;
                w_rd_addr  = w_count_nxt;
                w_regenb   = 1'b1;
                w_regsel   = 1'b1;
                w_countenb = 1'b1;
            end
            ST_DEQ_MOVE: begin
                w_we       = 1'b1;
                w_wr_addr  = ROOT;
                w_bram_sel = 1'b0;
            end
            ST_DEQ_CHILD: begin
                w_re        = 1'b1;
                w_rd_addr   = w_cur_nxt << 1;
                w_next_node = 1'b1;
                w_mux1_sel  = SEL_CHILDREN;
            end
            ST_DEQ_CMP: begin
                w_re       = 1'b1;
                w_rd_addr  = w_child_nxt;
                w_mux1_sel = SEL_PARENT;
            end
            ST_DEQ_SWAP: begin
                w_rd_addr  = w_child_nxt;
                w_wr_addr  = w_cur_nxt;
                w_bram_sel = 1'b1;
                w_mux1_sel = SEL_SWAP;
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    // State, index registers and registered outputs; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_cur     <= '0;
            r_child   <= '0;
            we        <= 1'b0;
            regenb    <= 1'b0;
            regsel    <= 1'b0;
            countenb  <= 1'b0;
            re        <= 1'b0;
            next_node <= 1'b0;
            bram_sel  <= 1'b0;
            rd_addr   <= '0;
            wr_addr   <= '0;
            mode      <= MODE_IDLE;
            mux1_sel  <= SEL_NONE;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_cur     <= w_cur_nxt;
            r_child   <= w_child_nxt;
            we        <= w_we;
            regenb    <= w_regenb;
            regsel    <= w_regsel;
            countenb  <= w_countenb;
            re        <= w_re;
            next_node <= w_next_node;
            bram_sel  <= w_bram_sel;
            rd_addr   <= w_rd_addr;
            wr_addr   <= w_wr_addr;
            mode      <= mode_of(w_state_nxt);
            mux1_sel  <= w_mux1_sel;
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: the stimulus process pushes the
// hand-computed output vector expected after each clock edge, and a
// separate monitor pops and compares it just after that edge.
module tb_control_fsm;

    typedef struct packed {
        logic        we;
        logic        regenb;
        logic        regsel;
        logic        countenb;
        logic        re;
        logic        next_node;
        logic        bram_sel;
        logic [2:0]  mode;
        logic [1:0]  mux1_sel;
        logic [31:0] rd_addr;
        logic [31:0] wr_addr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        enq, deq, done, result, full, swap_done, empty;
    logic        we, regenb, regsel, countenb, re, next_node, bram_sel;
    logic [31:0] rd_addr, wr_addr;
    logic [2:0]  mode;
    logic [1:0]  mux1_sel;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks;
    int    n_fail;

    control_fsm #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .enq(enq), .deq(deq), .done(done),
        .result(result), .full(full), .swap_done(swap_done), .empty(empty),
        .we(we), .regenb(regenb), .regsel(regsel), .countenb(countenb),
        .re(re), .next_node(next_node), .bram_sel(bram_sel),
        .rd_addr(rd_addr), .wr_addr(wr_addr), .mode(mode), .mux1_sel(mux1_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic w, input logic ren, input logic rsel,
                                input logic cen, input logic r, input logic nn,
                                input logic bs, input logic [2:0] md,
                                input logic [1:0] mx, input logic [31:0] ra,
                                input logic [31:0] wa);
        exp_t e;
        e.we = w; e.regenb = ren; e.regsel = rsel; e.countenb = cen;
        e.re = r; e.next_node = nn; e.bram_sel = bs; e.mode = md;
        e.mux1_sel = mx; e.rd_addr = ra; e.wr_addr = wa;
        return e;
    endfunction

    // Queue the expectation for the coming edge, then move to the next falling edge.
    task automatic tick(input string nm, input exp_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    // Monitor: one output vector per cycle, checked 1 time unit after the edge.
    initial begin
        exp_t  e;
        exp_t  a;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {we, regenb, regsel, countenb, re, next_node, bram_sel,
                      mode, mux1_sel, rd_addr, wr_addr};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: got we=%b regenb=%b regsel=%b countenb=%b re=%b nn=%b bsel=%b mode=%0d mux=%0d rd=%0d wr=%0d, expected we=%b regenb=%b regsel=%b countenb=%b re=%b nn=%b bsel=%b mode=%0d mux=%0d rd=%0d wr=%0d",
                             nm, a.we, a.regenb, a.regsel, a.countenb, a.re, a.next_node,
                             a.bram_sel, a.mode, a.mux1_sel, a.rd_addr, a.wr_addr,
                             e.we, e.regenb, e.regsel, e.countenb, e.re, e.next_node,
                             e.bram_sel, e.mode, e.mux1_sel, e.rd_addr, e.wr_addr);
                end
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    // Directed stimulus with hand-computed expected outputs.
    initial begin
        exp_t z;
        z = mk(0,0,0,0,0,0,0, 3'd0, 2'd0, 32'd0, 32'd0);
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; enq = 1'b0; deq = 1'b0; done = 1'b0; result = 1'b0;
        full = 1'b0; swap_done = 1'b0; empty = 1'b1;

        // Reset, then IDLE holds with no requests.
        tick("reset", z);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick("idle_hold", z);

        // First enqueue into empty heap: write node 1, then straight back to IDLE.
        enq = 1'b1;
        tick("enq1_wr", mk(1,1,0,1,0,0,0, 3'd1, 2'd0, 32'd0, 32'd1));
        enq = 1'b0;
        tick("enq1_idle", z);
        empty = 1'b0;

        // Second enqueue, smaller than parent: compare, swap held 3 cycles.
        enq = 1'b1; result = 1'b1;
        tick("enq2_wr", mk(1,1,0,1,0,0,0, 3'd1, 2'd0, 32'd0, 32'd2));
        enq = 1'b0;
        tick("enq2_cmp", mk(0,0,0,0,1,0,0, 3'd2, 2'd1, 32'd1, 32'd0));
        for (int i = 0; i < 3; i++)
            tick("enq2_swap_hold", mk(0,0,0,0,0,0,1, 3'd3, 2'd3, 32'd2, 32'd1));
        swap_done = 1'b1;
        tick("enq2_swap_done", z);
        swap_done = 1'b0; result = 1'b0;

        // Requests refused while full / empty.
        full = 1'b1; enq = 1'b1;
        for (int i = 0; i < 4; i++) tick("enq_while_full", z);
        full = 1'b0; enq = 1'b0;
        empty = 1'b1; deq = 1'b1;
        for (int i = 0; i < 4; i++) tick("deq_while_empty", z);
        empty = 1'b0; deq = 1'b0;

        // Simultaneous enq and deq: enqueue wins; parent smaller so no swap.
        enq = 1'b1; deq = 1'b1;
        tick("enq_priority_wr", mk(1,1,0,1,0,0,0, 3'd1, 2'd0, 32'd0, 32'd3));
        enq = 1'b0; deq = 1'b0;
        tick("enq3_cmp", mk(0,0,0,0,1,0,0, 3'd2, 2'd1, 32'd1, 32'd0));
        tick("enq3_no_swap", z);

        // Dequeue with three nodes: tail 3 moves to root, sift down to node 2.
        deq = 1'b1;
        tick("deq_rd", mk(0,1,1,1,1,0,0, 3'd4, 2'd0, 32'd3, 32'd0));
        deq = 1'b0;
        tick("deq_move", mk(1,0,0,0,0,0,0, 3'd4, 2'd0, 32'd0, 32'd1));
        result = 1'b1;
        tick("deq_child", mk(0,0,0,0,1,1,0, 3'd5, 2'd2, 32'd2, 32'd0));
        tick("deq_cmp", mk(0,0,0,0,1,0,0, 3'd5, 2'd1, 32'd2, 32'd0));
        tick("deq_swap", mk(0,0,0,0,0,0,1, 3'd6, 2'd3, 32'd2, 32'd1));
        swap_done = 1'b1;
        tick("deq_swap_done", z);
        swap_done = 1'b0; result = 1'b0;

        // done aborts an enqueue compare even though result is high (count 2 -> 3).
        enq = 1'b1;
        tick("enq4_wr", mk(1,1,0,1,0,0,0, 3'd1, 2'd0, 32'd0, 32'd3));
        enq = 1'b0; done = 1'b1; result = 1'b1;
        tick("enq4_cmp", mk(0,0,0,0,1,0,0, 3'd2, 2'd1, 32'd1, 32'd0));
        tick("enq4_done_abort", z);
        done = 1'b0; result = 1'b0;

        // Reset mid-dequeue aborts and clears count: next enq writes node 1.
        deq = 1'b1;
        tick("deq2_rd", mk(0,1,1,1,1,0,0, 3'd4, 2'd0, 32'd3, 32'd0));
        deq = 1'b0; rst = 1'b1;
        tick("reset_mid_op", z);
        rst = 1'b0; enq = 1'b1;
        tick("enq_after_reset", mk(1,1,0,1,0,0,0, 3'd1, 2'd0, 32'd0, 32'd1));
        enq = 1'b0;
        tick("enq_after_reset_idle", z);

        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Control state machine for the QuickQ hardware priority queue, a binary min-heap held in BRAM with 1-based node indices (root = 1).
- Sequences enqueue (append at the tail, then sift up) and dequeue (move the tail to the root, then sift down).
- Drives BRAM read/write enables and addresses, the element-register load/select, the occupancy-counter enable, and the datapath mux/mode selects.
- Uses comparator and swap-unit status from the datapath.

Parameters:
- ADDR_W, 32, width of rd_addr, wr_addr and the internal count/cur/child registers.

Ports:
- clk  in  1  system clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- enq  in  1  enqueue request; sampled in IDLE only
- deq  in  1  dequeue request; sampled in IDLE only
- done  in  1  datapath abort/complete; in any compare state it forces a return to IDLE
- result  in  1  comparator output; meaning depends on state (see Behaviour)
- full  in  1  occupancy counter full
- swap_done  in  1  swap unit has finished the current two-node exchange
- empty  in  1  occupancy counter empty
- we  out  1  BRAM write enable
- regenb  out  1  element register load enable
- regsel  out  1  element register source: 0 = enqueue input, 1 = BRAM read data
- countenb  out  1  occupancy counter step; direction is set by mode (ENQ increments, DEQ decrements)
- re  out  1  BRAM read enable
- next_node  out  1  datapath selects child-pair comparison
- bram_sel  out  1  BRAM write-data source: 0 = element register, 1 = swap unit
- rd_addr  out  ADDR_W  BRAM read address
- wr_addr  out  ADDR_W  BRAM write address
- mode  out  3  operation class, for the datapath
- mux1_sel  out  2  comparator operand select

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Moore outputs: every output is decoded from the current state and registers only. Any output not listed for a state is 0.
- Internal registers:
  - count: mirrors the occupancy counter.
  - cur: current node index.
  - child: selected child index.
- Reset: state = IDLE; count = cur = child = 0; all outputs 0; mode = 0. Reset mid-operation aborts immediately. count is cleared; the external counter is the datapath's responsibility.
- IDLE (mode 0):
  - enq && !full → ENQ_WR.
  - Else deq && !empty → DEQ_RD.
  - enq has priority when both are asserted.
  - enq while full, or deq while empty: ignored, stay in IDLE, no side effects.
- ENQ_WR (mode 1), one cycle:
  - Outputs: we = 1, wr_addr = count + 1, regenb = 1, regsel = 0, countenb = 1.
  - Updates: count ← count + 1; cur ← count + 1.
  - Next: if the new cur == 1 → IDLE, else ENQ_CMP.
- ENQ_CMP (mode 2):
  - Outputs: re = 1, rd_addr = cur >> 1 (parent), mux1_sel = 1.
  - result = 1 means the new node is smaller than its parent.
  - Next: done → IDLE; result → ENQ_SWAP; otherwise IDLE.
- ENQ_SWAP (mode 3):
  - Outputs: rd_addr = cur, wr_addr = cur >> 1, bram_sel = 1, mux1_sel = 3.
  - Hold until swap_done. If swap_done is already high on entry, the state lasts one cycle.
  - On swap_done: cur ← cur >> 1; if cur >> 1 == 1 → IDLE, else ENQ_CMP.
- DEQ_RD (mode 4), one cycle:
  - Outputs: re = 1, rd_addr = count (tail), regenb = 1, regsel = 1, countenb = 1.
  - Update: count ← count − 1.
  - Next: DEQ_MOVE.
- DEQ_MOVE (mode 4), one cycle:
  - Outputs: we = 1, wr_addr = 1, bram_sel = 0.
  - Update: cur ← 1.
  - Next: if count ≤ 1 → IDLE, else DEQ_CHILD.
- DEQ_CHILD (mode 5):
  - Outputs: re = 1, rd_addr = 2·cur, next_node = 1, mux1_sel = 2.
  - result = 1 means the right child is smaller.
  - child ← 2·cur + (result && 2·cur + 1 ≤ count).
  - Next: done → IDLE; else DEQ_CMP.
- DEQ_CMP (mode 5):
  - Outputs: re = 1, rd_addr = child, mux1_sel = 1.
  - result = 1 means the child is smaller than cur.
  - Next: done or !result → IDLE; result → DEQ_SWAP.
- DEQ_SWAP (mode 6):
  - Outputs: rd_addr = child, wr_addr = cur, bram_sel = 1, mux1_sel = 3.
  - Hold until swap_done.
  - On swap_done: cur ← child; if 2·child > count → IDLE, else DEQ_CHILD.
- mode 7 is unused. An illegal state recovers to IDLE on the next clock.
- enq/deq asserted outside IDLE are ignored; no queuing. Requesters hold the request until the FSM returns to IDLE.
- Arithmetic is unsigned ADDR_W; shifts are logical.

Decomposition:
- Shared package quickq_pkg:
  - state_t enum.
  - mode encodings MODE_IDLE = 0 … MODE_DEQ_SWAP = 6.
  - mux1_sel constants: SEL_NONE = 0, SEL_PARENT = 1, SEL_CHILDREN = 2, SEL_SWAP = 3.
  - ROOT_ADDR = 1.
- Single module; no sub-module is warranted.

Test Plan:
- Reset: rst = 1 for one cycle → all outputs 0, mode = 0, and IDLE persists 4 cycles with no requests.
- First enq (empty = 1, full = 0):
  - 1-cycle enq pulse → next cycle we = 1, wr_addr = 1, countenb = 1, mode = 1.
  - Following cycle → IDLE, count = 1.
- Second enq with result = 1:
  - ENQ_WR shows wr_addr = 2.
  - ENQ_CMP shows rd_addr = 1.
  - With swap_done = 0 for 3 cycles, ENQ_SWAP (mode = 3, rd_addr = 2, wr_addr = 1) is held 3 cycles.
  - swap_done = 1 → IDLE next cycle.
- full = 1 with enq = 1 for 4 cycles → remains in IDLE; we = countenb = 0 throughout. deq = 1 with empty = 1 → likewise ignored.
- enq = deq = 1 simultaneously with full = empty = 0 → ENQ_WR is taken (mode = 1).
- Dequeue with count = 3:
  - Sequence: DEQ_RD (rd_addr = 3), DEQ_MOVE (wr_addr = 1), DEQ_CHILD (rd_addr = 2).
  - With result = 1 in DEQ_CHILD, DEQ_CMP has rd_addr = 2 (tail 3 was removed).
  - result = 1 → DEQ_SWAP (wr_addr = 1, rd_addr = 2); swap_done → IDLE, since 2·2 > 2.
